// File: rtl/uart_rx_core_if.sv
// Signal bundle between the UART receiver core and the logic that consumes its words.
// The master side is the receiver itself; the slave side drives the line and reads results.
interface uart_rx_core_if #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
);
    logic                  serial_in;
    logic [CNT_WIDTH-1:0]  clks_per_bit;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  rx_start_pulse;
    logic                  rx_done_pulse;
    logic                  rx_error;
    logic                  rx_busy;

    modport master (
        input  serial_in,
        input  clks_per_bit,
        output data_out,
        output rx_start_pulse,
        output rx_done_pulse,
        output rx_error,
        output rx_busy
    );

    modport slave (
        output serial_in,
        output clks_per_bit,
        input  data_out,
        input  rx_start_pulse,
        input  rx_done_pulse,
        input  rx_error,
        input  rx_busy
    );
endinterface

// File: rtl/uart_rx_core.sv
// UART receiver: 2-FF synchronizer, 3-sample majority vote, centre sampling of
// LSB-first data bits and one stop bit, with start/done/error pulses.
module uart_rx_core #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic           clk_16mhz,
    input  logic           rstn,
    uart_rx_core_if.master rx
);
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_W-1:0]     LAST_BIT = BIT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] MIN_C    = CNT_WIDTH'(8);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t                state, state_next;
    logic                  sync1, rx_s;
    logic [2:0]            maj_sr;
    logic                  voted;
    logic [CNT_WIDTH-1:0]  cnt, cnt_next;
    logic [CNT_WIDTH-1:0]  c_reg, c_next, c_in;
    logic [CNT_WIDTH-1:0]  half_m1, full_m1;
    logic [BIT_W-1:0]      bit_idx, bit_idx_next;
    logic [DATA_WIDTH-1:0] shift_reg, shift_next;
    logic [DATA_WIDTH-1:0] data_reg, data_next;
    logic                  start_p, start_next;
    logic                  done_p, done_next;
    logic                  err_p, err_next;

    assign voted   = (maj_sr[0] & maj_sr[1]) | (maj_sr[0] & maj_sr[2]) | (maj_sr[1] & maj_sr[2]);
    assign c_in    = (rx.clks_per_bit < MIN_C) ? MIN_C : rx.clks_per_bit;
    // Counter runs 0..target, so the start sample lands H cycles after T0 and data samples every C.
    assign half_m1 = (c_reg >> 1) - CNT_WIDTH'(1);
    assign full_m1 = c_reg - CNT_WIDTH'(1);

    always_ff @(posedge clk_16mhz or negedge rstn) begin
        if (!rstn) begin
            sync1     <= 1'b1;
            rx_s      <= 1'b1;
            maj_sr    <= 3'b111;
            state     <= IDLE;
            cnt       <= '0;
            c_reg     <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            data_reg  <= '0;
            start_p   <= 1'b0;
            done_p    <= 1'b0;
            err_p     <= 1'b0;
        end else begin
            sync1     <= rx.serial_in;
            rx_s      <= sync1;
            maj_sr    <= {maj_sr[1:0], rx_s};
            state     <= state_next;
            cnt       <= cnt_next;
            c_reg     <= c_next;
            bit_idx   <= bit_idx_next;
            shift_reg <= shift_next;
            data_reg  <= data_next;
            start_p   <= start_next;
            done_p    <= done_next;
            err_p     <= err_next;
        end
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        c_next       = c_reg;
        bit_idx_next = bit_idx;
        shift_next   = shift_reg;
        data_next    = data_reg;
        start_next   = 1'b0;
        done_next    = 1'b0;
        err_next     = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    c_next     = c_in;
                    cnt_next   = '0;
                    state_next = START;
                end
            end
            START: begin
                if (cnt == half_m1) begin
                    cnt_next = '0;
                    if (!voted) begin
                        start_next   = 1'b1;
                        bit_idx_next = '0;
                        state_next   = DATA;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt + CNT_WIDTH'(1);
                end
            end
            DATA: begin
                if (cnt == full_m1) begin
                    cnt_next   = '0;
                    shift_next = {voted, shift_reg[DATA_WIDTH-1:1]};
                    if (bit_idx == LAST_BIT) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx + BIT_W'(1);
                    end
                end else begin
                    cnt_next = cnt + CNT_WIDTH'(1);
                end
            end
            STOP: begin
                // Leave right at the stop-bit centre so a back-to-back start edge is not missed.
                if (cnt == full_m1) begin
                    cnt_next = '0;
                    if (voted) begin
                        data_next  = shift_reg;
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        err_next   = 1'b1;
                        state_next = WAIT_IDLE;
                    end
                end else begin
                    cnt_next = cnt + CNT_WIDTH'(1);
                end
            end
            WAIT_IDLE: begin
                if (rx_s) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign rx.data_out       = data_reg;
    assign rx.rx_start_pulse = start_p;
    assign rx.rx_done_pulse  = done_p;
    assign rx.rx_error       = err_p;
    assign rx.rx_busy        = (state != IDLE);
endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: directed frames are queued as expected events and a
// monitor pops and compares them whenever the receiver pulses done or error.
`timescale 1ns/1ps
module tb_uart_rx_core;
    logic clk_16mhz = 1'b0;
    logic rstn      = 1'b0;

    uart_rx_core_if #(.DATA_WIDTH(8), .CNT_WIDTH(16)) rx_if ();

    uart_rx_core #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk_16mhz (clk_16mhz),
        .rstn      (rstn),
        .rx        (rx_if.master)
    );

    always #31.25 clk_16mhz = ~clk_16mhz;

    typedef struct {
        logic       is_err;
        logic [7:0] data;
        int         exp_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc         = 0;
    int   vectors     = 0;
    int   miscompares = 0;
    int   start_count = 0;
    int   last_start_cyc = -1;

    always @(posedge clk_16mhz) cyc <= cyc + 1;

    task automatic check_output(input string name, input int actual, input int expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
        end
    endtask

    // Monitor: every done/error pulse consumes one queued expectation.
    always @(negedge clk_16mhz) begin
        exp_t e;
        if (rx_if.rx_start_pulse) begin
            start_count++;
            last_start_cyc = cyc;
        end
        if (rx_if.rx_done_pulse || rx_if.rx_error) begin
            if (rx_if.rx_done_pulse && rx_if.rx_error)
                check_output("done_error_exclusive", 1, 0);
            if (exp_q.size() == 0) begin
                check_output("unexpected_event", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check_output("event_is_error", int'(rx_if.rx_error), int'(e.is_err));
                check_output("data_out", int'(rx_if.data_out), int'(e.data));
                if (e.exp_cyc >= 0)
                    check_output("event_cycle", cyc, e.exp_cyc);
            end
        end
    end

    task automatic apply_stimulus(input logic [7:0] data, input int c, input logic stop_bit,
                                  input int stop_len, input int glitch_at);
        int   total;
        logic v;
        total = 9 * c + stop_len;
        for (int off = 0; off < total; off++) begin
            if (off < c)          v = 1'b0;
            else if (off < 9 * c) v = data[(off - c) / c];
            else                  v = stop_bit;
            if (off == glitch_at) v = ~v;
            rx_if.serial_in = v;
            @(negedge clk_16mhz);
        end
    endtask

    task automatic expect_event(input logic is_err, input logic [7:0] data, input int exp_cyc);
        exp_t e;
        e.is_err  = is_err;
        e.data    = data;
        e.exp_cyc = exp_cyc;
        exp_q.push_back(e);
    endtask

    task automatic finish_test(input string name);
        repeat (20) @(negedge clk_16mhz);
        check_output({name, "_pending_events"}, exp_q.size(), 0);
    endtask

    initial begin
        #20_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int         n0;
        int         sc;
        logic [7:0] last_good;

        rx_if.serial_in    = 1'b1;
        rx_if.clks_per_bit = 16'd16;
        rstn               = 1'b0;
        repeat (3) @(negedge clk_16mhz);
        check_output("reset_outputs",
                     int'({rx_if.data_out, rx_if.rx_start_pulse, rx_if.rx_done_pulse, rx_if.rx_error, rx_if.rx_busy}), 0);
        rstn = 1'b1;
        repeat (5) @(negedge clk_16mhz);

        // Test 1: C=16, 0x55; start pulse at T0+9, done at T0+153 (T0 = drive cycle + 2).
        sc = start_count;
        n0 = cyc;
        expect_event(1'b0, 8'h55, n0 + 155);
        apply_stimulus(8'h55, 16, 1'b1, 16, -1);
        check_output("t1_start_cycle", last_start_cyc, n0 + 11);
        check_output("t1_start_count", start_count - sc, 1);
        finish_test("t1");

        // Test 2: C=139, back-to-back frames with the first stop bit cut short.
        rx_if.clks_per_bit = 16'd139;
        sc = start_count;
        expect_event(1'b0, 8'hA3, -1);
        expect_event(1'b0, 8'h0F, -1);
        apply_stimulus(8'hA3, 139, 1'b1, 79, -1);
        apply_stimulus(8'h0F, 139, 1'b1, 139, -1);
        check_output("t2_start_count", start_count - sc, 2);
        finish_test("t2");

        // Test 3: 3-cycle low glitch is rejected at the start sample.
        rx_if.clks_per_bit = 16'd16;
        sc = start_count;
        n0 = cyc;
        rx_if.serial_in = 1'b0;
        repeat (3) @(negedge clk_16mhz);
        rx_if.serial_in = 1'b1;
        check_output("t3_busy_after_edge", int'(rx_if.rx_busy), 1);
        repeat (8) @(negedge clk_16mhz);
        check_output("t3_cycle_check", cyc, n0 + 11);
        check_output("t3_busy_dropped", int'(rx_if.rx_busy), 0);
        check_output("t3_start_count", start_count - sc, 0);
        finish_test("t3");

        // Test 5: glitch inside the bit-3 vote window; mid-frame divisor change is ignored.
        n0 = cyc;
        expect_event(1'b0, 8'h81, n0 + 155);
        fork
            begin
                repeat (40) @(negedge clk_16mhz);
                rx_if.clks_per_bit = 16'd50;
            end
        join_none
        apply_stimulus(8'h81, 16, 1'b1, 16, 70);
        rx_if.clks_per_bit = 16'd16;
        finish_test("t5");

        // Clamp: clks_per_bit=3 behaves as C=8, done at T0+77.
        rx_if.clks_per_bit = 16'd3;
        n0 = cyc;
        expect_event(1'b0, 8'hC6, n0 + 79);
        apply_stimulus(8'hC6, 8, 1'b1, 8, -1);
        rx_if.clks_per_bit = 16'd16;
        finish_test("t7");
        last_good = 8'hC6;

        // Test 4: framing error, then line held low; no new frame until it returns high.
        n0 = cyc;
        expect_event(1'b1, last_good, n0 + 155);
        apply_stimulus(8'h3C, 16, 1'b0, 16, -1);
        sc = start_count;
        rx_if.serial_in = 1'b0;
        repeat (50) @(negedge clk_16mhz);
        check_output("t4_busy_while_low", int'(rx_if.rx_busy), 1);
        check_output("t4_no_new_start", start_count - sc, 0);
        check_output("t4_data_kept", int'(rx_if.data_out), int'(last_good));
        rx_if.serial_in = 1'b1;
        repeat (10) @(negedge clk_16mhz);
        check_output("t4_busy_released", int'(rx_if.rx_busy), 0);
        finish_test("t4");

        // Test 6: reset mid-DATA of 0xFF abandons the frame.
        sc = start_count;
        rx_if.serial_in = 1'b0;
        repeat (16) @(negedge clk_16mhz);
        rx_if.serial_in = 1'b1;
        repeat (56) @(negedge clk_16mhz);
        check_output("t6_busy_mid_frame", int'(rx_if.rx_busy), 1);
        check_output("t6_start_seen", start_count - sc, 1);
        rstn = 1'b0;
        #1;
        check_output("t6_reset_outputs",
                     int'({rx_if.data_out, rx_if.rx_start_pulse, rx_if.rx_done_pulse, rx_if.rx_error, rx_if.rx_busy}), 0);
        repeat (3) @(negedge clk_16mhz);
        rstn = 1'b1;
        repeat (200) @(negedge clk_16mhz);
        check_output("t6_no_pulse_after_reset", int'(rx_if.data_out), 0);
        n0 = cyc;
        expect_event(1'b0, 8'h12, n0 + 155);
        apply_stimulus(8'h12, 16, 1'b1, 16, -1);
        finish_test("t6");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
Standalone UART receiver core, instantiated on the RX side of uart_top_level_interface.
- Synchronizes serial_in into the 16 MHz domain.
- Detects and validates the start bit, then samples DATA_WIDTH data bits LSB-first at bit centres, using 3-sample majority voting.
- Checks one stop bit, then emits the byte with a done pulse, or flags a framing error.
- Frame format is fixed: 8N1 by default, no parity.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (5..9 supported).
CNT_WIDTH, 16, width of the bit-period counter and of clks_per_bit.

Ports:
clk_16mhz  input  1  system clock, 16 MHz
rstn  input  1  asynchronous active-low reset
serial_in  input  1  raw UART line; idle high; asynchronous to clk_16mhz
clks_per_bit  input  CNT_WIDTH  clock cycles per bit (e.g. 139 for 115200 baud); latched at start detect
data_out  output  DATA_WIDTH  last correctly received word
rx_start_pulse  output  1  one-cycle pulse when a start bit is validated
rx_done_pulse  output  1  one-cycle pulse; data_out is valid in this cycle and holds until the next done
rx_error  output  1  one-cycle pulse on framing error (stop bit sampled 0)
rx_busy  output  1  high in every state other than IDLE

Behaviour:
- Reset (rstn=0, asynchronous):
  - State returns to IDLE; all counters clear.
  - data_out, rx_start_pulse, rx_done_pulse, rx_error and rx_busy go to 0.
  - Synchronizer flops and majority shift register are set to 1, the idle line level.
  - Reset asserted mid-frame abandons the frame: no pulse is emitted and data_out is not updated.
- Synchronizer and voting:
  - 2-FF synchronizer produces rx_s.
  - A 3-bit shift register holds the last 3 rx_s values.
  - The sampled bit at each sample point is the majority of those 3 values.
- Divisor:
  - C = clks_per_bit, clamped to 8 if below 8, latched into an internal register when leaving IDLE.
  - H = C >> 1.
  - Changing clks_per_bit mid-frame has no effect until the next frame.
- Timing: T0 is the cycle in which IDLE first sees rx_s = 0.
  - Start sample occurs at T0+H.
  - Data bit i (i = 0..DATA_WIDTH-1) is sampled at T0+H+(i+1)*C.
  - Stop bit is sampled at T0+H+(DATA_WIDTH+1)*C.
  - All outputs are registered and assert in the cycle after the corresponding sample point.
- States:
  - IDLE: wait for rx_s = 0; load the counter and go to START.
  - START: at count H, vote the sample. If 0, pulse rx_start_pulse and go to DATA with bit index 0. If 1, treat it as a glitch and return to IDLE with no output.
  - DATA: every C cycles, shift the voted bit into bit[DATA_WIDTH-1] of the shift register (LSB-first). After DATA_WIDTH samples, go to STOP.
  - STOP: after C cycles, vote the sample.
    - If 1: load data_out from the shift register, pulse rx_done_pulse and go to IDLE. The stop-bit remainder is not waited out, so a back-to-back start edge is caught.
    - If 0: pulse rx_error, leave data_out unchanged and go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s = 1 for one cycle (break / line-low hold), then return to IDLE.
- Pulse rules:
  - rx_done_pulse and rx_error are mutually exclusive.
  - Each pulse is exactly one cycle wide.
  - No pulse asserts in IDLE.
- Counter: compare-to-target style (counts 0..C-1) with no wrap hazard. C up to 2^CNT_WIDTH-1 is supported.

Test Plan:
1. C=16, frame 0x55 (start, 1,0,1,0,1,0,1,0 LSB-first, stop=1) -> rx_start_pulse 1 cycle after T0+8; rx_done_pulse at T0+153; data_out=0x55; rx_error stays 0.
2. C=139, frames 0xA3 then 0x0F back-to-back (start edge immediately after stop sample) -> two rx_done_pulses; data_out=0xA3 then 0x0F; no missed frame.
3. Line low for 3 cycles then high, C=16 -> no rx_start_pulse; returns to IDLE; rx_busy drops by T0+9.
4. Frame 0x3C with stop bit driven 0, line held low for 50 cycles -> single rx_error pulse; no rx_done_pulse; data_out keeps its previous value; no new frame until the line returns high.
5. C=16, frame 0x81 with a 1-cycle inverted glitch exactly at the bit-3 sample point -> majority vote rejects it; data_out=0x81.
6. rstn pulsed low at mid-DATA of frame 0xFF -> all outputs 0 immediately; no pulses; next clean frame 0x12 is received correctly.
